gumnut_port_timer: RTL and testbench

Port-bus responder for the Gumnut core: an 8-bit programmable down-counter timer mapped into the core's I/O port space. It answers the core's port read/write cycles with a configurable-latency acknowledge, and drives the core's interrupt request/acknowledge pair. It sits on the core side of the port bus, alongside other port-mapped peripherals, and its `port_ack_o` is ORed into the core's `port_ack_i`.

---
 rtl/gumnut_port_pkg.sv | 34 +++
 rtl/gumnut_port_timer_core.sv | 129 ++++++++++++
 rtl/gumnut_port_timer.sv | 165 ++++++++++++++++
 tb/tb_gumnut_port_timer.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gumnut_port_pkg.sv
`default_nettype none
// ============================================================================
// Module  : gumnut_port_pkg
// Purpose : Shared definitions for the Gumnut port-mapped timer:
//           register offsets, CTRL/STATUS bit positions and the bus FSM
//           state type.
// Rev     : 1.0  initial release
// ============================================================================
package gumnut_port_pkg;

  // Register offsets within the four-port window
  localparam logic [1:0] OFS_CTRL   = 2'd0;
  localparam logic [1:0] OFS_STATUS = 2'd1;
  localparam logic [1:0] OFS_RELOAD = 2'd2;
  localparam logic [1:0] OFS_COUNT  = 2'd3;

  // CTRL bit positions
  localparam int CTRL_EN = 0;
  localparam int CTRL_IE = 1;
  localparam int CTRL_AR = 2;

  // STATUS bit positions
  localparam int STAT_EXP  = 0;
  localparam int STAT_PEND = 1;

  // Bus responder states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } port_fsm_t;

endpackage : gumnut_port_pkg
`default_nettype wire

// File: rtl/gumnut_port_timer_core.sv
`default_nettype none
// ============================================================================
// Module  : port_timer_core
// Purpose : Prescaler, 8-bit down-counter, expiry flag and interrupt
//           pending flag of the Gumnut port timer.
// Ports   : clk_i/rst_i     clock, synchronous active-high reset
//           *_we_i          one-cycle decoded register write strobes
//           wdata_i         write data for the strobed register
//           int_ack_i       interrupt acknowledge pulse from the core
//           ctrl_o          {AR, IE, EN}
//           exp_o, pend_o   expiry flag, interrupt pending flag
//           reload_o        RELOAD register
//           count_o         current COUNT value
// Rev     : 1.0  initial release
// ============================================================================
module port_timer_core
  import gumnut_port_pkg::*;
#(
  parameter int PRESCALE = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       ctrl_we_i,
  input  logic       status_we_i,
  input  logic       reload_we_i,
  input  logic       count_we_i,
  input  logic [7:0] wdata_i,
  input  logic       int_ack_i,
  output logic [2:0] ctrl_o,
  output logic       exp_o,
  output logic       pend_o,
  output logic [7:0] reload_o,
  output logic [7:0] count_o
);

  localparam logic [7:0] PS_LAST = 8'(PRESCALE - 1);

  logic [2:0] ctrl_q,   ctrl_d;
  logic       exp_q,    exp_d;
  logic       pend_q,   pend_d;
  logic [7:0] reload_q, reload_d;
  logic [7:0] count_q,  count_d;
  logic [7:0] presc_q,  presc_d;
  logic       tick;

  always_comb begin
    ctrl_d   = ctrl_q;
    exp_d    = exp_q;
    pend_d   = pend_q;
    reload_d = reload_q;
    count_d  = count_q;
    presc_d  = presc_q;

    tick = ctrl_q[CTRL_EN] && (presc_q == PS_LAST);

    if (ctrl_q[CTRL_EN]) begin
      presc_d = tick ? 8'd0 : presc_q + 8'd1;
    end

    // Clears are evaluated before the expiry sets so that a coincident
    // expiry leaves the flags set.
    if (status_we_i && wdata_i[STAT_EXP]) begin
      exp_d  = 1'b0;
      pend_d = 1'b0;
    end
    if (int_ack_i) begin
      pend_d = 1'b0;
    end

    if (tick) begin
      if (count_q != 8'd0) begin
        count_d = count_q - 8'd1;
      end else begin
        exp_d = 1'b1;
        if (ctrl_q[CTRL_IE]) begin
          pend_d = 1'b1;
        end
        if (ctrl_q[CTRL_AR]) begin
          count_d = reload_q;
        end else begin
          ctrl_d[CTRL_EN] = 1'b0;
        end
      end
    end

    // Register writes come last so they override the tick's effect on
    // COUNT and on the CTRL bits.
    if (reload_we_i) begin
      reload_d = wdata_i;
    end
    if (count_we_i) begin
      count_d = wdata_i;
      presc_d = 8'd0;
    end
    if (ctrl_we_i) begin
      ctrl_d = wdata_i[2:0];
      if (!ctrl_q[CTRL_EN] && wdata_i[CTRL_EN]) begin
        count_d = reload_q;
        presc_d = 8'd0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ctrl_q   <= 3'd0;
      exp_q    <= 1'b0;
      pend_q   <= 1'b0;
      reload_q <= 8'hFF;
      count_q  <= 8'd0;
      presc_q  <= 8'd0;
    end else begin
      ctrl_q   <= ctrl_d;
      exp_q    <= exp_d;
      pend_q   <= pend_d;
      reload_q <= reload_d;
      count_q  <= count_d;
      presc_q  <= presc_d;
    end
  end

  assign ctrl_o   = ctrl_q;
  assign exp_o    = exp_q;
  assign pend_o   = pend_q;
  assign reload_o = reload_q;
  assign count_o  = count_q;

endmodule : port_timer_core
`default_nettype wire

// File: rtl/gumnut_port_timer.sv
`default_nettype none
// ============================================================================
// Module  : gumnut_port_timer
// Purpose : Port-bus responder for the Gumnut core wrapping an 8-bit
//           programmable down-counter timer. Decodes BASE_ADDR..+3,
//           acknowledges after WAIT_STATES extra cycles and drives the
//           interrupt request.
// Ports   : clk_i, rst_i           clock, synchronous active-high reset
//           port_cyc_i/stb_i       bus cycle / strobe from the core
//           port_we_i              1 = write, 0 = read
//           port_adr_i/dat_i       address / write data
//           port_dat_o             read data, zero outside the ack cycle
//           port_ack_o             one-cycle acknowledge
//           int_req_o / int_ack_i  interrupt request / acknowledge
// Rev     : 1.0  initial release
// ============================================================================
module gumnut_port_timer
  import gumnut_port_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR   = 8'h10,
  parameter int         PRESCALE    = 16,
  parameter int         WAIT_STATES = 1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       port_cyc_i,
  input  logic       port_stb_i,
  input  logic       port_we_i,
  input  logic [7:0] port_adr_i,
  input  logic [7:0] port_dat_i,
  output logic [7:0] port_dat_o,
  output logic       port_ack_o,
  output logic       int_req_o,
  input  logic       int_ack_i
);

  localparam logic [2:0] WS_LAST = 3'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  port_fsm_t  state_q, state_d;
  logic [2:0] wcnt_q,  wcnt_d;
  logic       we_q,    we_d;
  logic [1:0] off_q,   off_d;
  logic [7:0] wdat_q,  wdat_d;
  logic [7:0] rdat_q,  rdat_d;

  logic       req;
  logic       enter_ack;
  logic [1:0] rd_off;
  logic       rd_we;
  logic [7:0] rd_val;
  logic       commit;

  logic [2:0] ctrl;
  logic       exp_flag;
  logic       pend_flag;
  logic [7:0] reload;
  logic [7:0] count;

  assign req = port_cyc_i && port_stb_i && (port_adr_i[7:2] == BASE_ADDR[7:2]);

  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    we_d      = we_q;
    off_d     = off_q;
    wdat_d    = wdat_q;
    enter_ack = 1'b0;

    case (state_q)
      IDLE: begin
        if (req) begin
          we_d   = port_we_i;
          off_d  = port_adr_i[1:0];
          wdat_d = port_dat_i;
          if (WAIT_STATES == 0) begin
            state_d   = ACK;
            enter_ack = 1'b1;
          end else begin
            state_d = WAIT;
            wcnt_d  = WS_LAST;
          end
        end
      end
      WAIT: begin
        // The core withdrawing the request cancels the access outright.
        if (!(port_cyc_i && port_stb_i)) begin
          state_d = IDLE;
        end else if (wcnt_q == 3'd0) begin
          state_d   = ACK;
          enter_ack = 1'b1;
        end else begin
          wcnt_d = wcnt_q - 3'd1;
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // With zero wait states the request fields are not latched yet when the
  // read data is captured, so take them straight from the bus.
  assign rd_off = (state_q == IDLE) ? port_adr_i[1:0] : off_q;
  assign rd_we  = (state_q == IDLE) ? port_we_i       : we_q;

  always_comb begin
    rd_val = 8'h00;
    case (rd_off)
      OFS_CTRL:   rd_val = {5'b0, ctrl};
      OFS_STATUS: rd_val = {6'b0, pend_flag, exp_flag};
      OFS_RELOAD: rd_val = reload;
      OFS_COUNT:  rd_val = count;
      default:    rd_val = 8'h00;
    endcase
    rdat_d = (enter_ack && !rd_we) ? rd_val : 8'h00;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      wcnt_q  <= 3'd0;
      we_q    <= 1'b0;
      off_q   <= 2'd0;
      wdat_q  <= 8'd0;
      rdat_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      we_q    <= we_d;
      off_q   <= off_d;
      wdat_q  <= wdat_d;
      rdat_q  <= rdat_d;
    end
  end

  // Writes take effect on the edge that closes the ACK cycle.
  assign commit = (state_q == ACK) && we_q;

  port_timer_core #(
    .PRESCALE (PRESCALE)
  ) u_core (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .ctrl_we_i   (commit && (off_q == OFS_CTRL)),
    .status_we_i (commit && (off_q == OFS_STATUS)),
    .reload_we_i (commit && (off_q == OFS_RELOAD)),
    .count_we_i  (commit && (off_q == OFS_COUNT)),
    .wdata_i     (wdat_q),
    .int_ack_i   (int_ack_i),
    .ctrl_o      (ctrl),
    .exp_o       (exp_flag),
    .pend_o      (pend_flag),
    .reload_o    (reload),
    .count_o     (count)
  );

  assign port_ack_o = (state_q == ACK);
  assign port_dat_o = rdat_q;
  assign int_req_o  = pend_flag;

endmodule : gumnut_port_timer
`default_nettype wire

// File: tb/tb_gumnut_port_timer.sv
`default_nettype none
// ============================================================================
// Module  : tb_gumnut_port_timer
// Purpose : Self-checking bench for gumnut_port_timer. One instance with
//           one wait state and PRESCALE 4, one with three wait states.
// Rev     : 1.0  initial release
// ============================================================================
module tb_gumnut_port_timer;

  localparam logic [7:0] BASE = 8'h10;
  localparam int         P    = 4;
  localparam logic [1:0] O_CTRL = 2'd0, O_STAT = 2'd1, O_REL = 2'd2, O_CNT = 2'd3;

  logic       clk = 1'b0;
  logic       rst;
  logic       cyc0, cyc3, stb, we, int_ack;
  logic [7:0] adr, dat_i;
  logic [7:0] dat0, dat3;
  logic       ack0, ack3, irq0, irq3;

  int edge_cnt = 0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  gumnut_port_timer #(.BASE_ADDR(BASE), .PRESCALE(P), .WAIT_STATES(1)) u_dut (
    .clk_i(clk), .rst_i(rst), .port_cyc_i(cyc0), .port_stb_i(stb), .port_we_i(we),
    .port_adr_i(adr), .port_dat_i(dat_i), .port_dat_o(dat0), .port_ack_o(ack0),
    .int_req_o(irq0), .int_ack_i(int_ack)
  );

  gumnut_port_timer #(.BASE_ADDR(BASE), .PRESCALE(P), .WAIT_STATES(3)) u_dut3 (
    .clk_i(clk), .rst_i(rst), .port_cyc_i(cyc3), .port_stb_i(stb), .port_we_i(we),
    .port_adr_i(adr), .port_dat_i(dat_i), .port_dat_o(dat3), .port_ack_o(ack3),
    .int_req_o(irq3), .int_ack_i(int_ack)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Starts #1 after a rising edge; returns #1 after a rising edge.
  // lat = cycles from request cycle to ack cycle; a = edge that opened ACK.
  task automatic bus(input bit s3, input bit w, input logic [7:0] ad, input logic [7:0] wd,
                     input int max_cyc, output logic [7:0] rd, output bit acked,
                     output int lat, output int a);
    int  n;
    logic ak;
    rd = 8'h00; acked = 1'b0; lat = -1; a = edge_cnt; n = 0;
    if (s3) cyc3 = 1'b1; else cyc0 = 1'b1;
    stb = 1'b1; we = w; adr = ad; dat_i = wd;
    while (!acked && n <= max_cyc) begin
      @(negedge clk);
      ak = s3 ? ack3 : ack0;
      if (ak) begin
        acked = 1'b1; lat = n; a = edge_cnt;
        rd = s3 ? dat3 : dat0;
      end else begin
        chk("dat_zero_no_ack", s3 ? dat3 : dat0, 8'h00);
      end
      @(posedge clk); #1;
      n++;
    end
    cyc0 = 1'b0; cyc3 = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic xfer(input bit s3, input bit w, input logic [1:0] off, input logic [7:0] wd,
                      output logic [7:0] rd, output int a);
    bit ok;
    int lat;
    bus(s3, w, BASE + {6'b0, off}, wd, 12, rd, ok, lat, a);
    chk("acked", ok, 1);
    chk("ack_latency", lat, s3 ? 4 : 2);
  endtask

  task automatic wait_edge(input int n);
    while (edge_cnt < n) begin @(posedge clk); #1; end
  endtask

  // Timer behaviour from the rules: k = edges since EN was loaded; a tick
  // happens every P edges. Returns COUNT, EXP and EN after those k edges.
  function automatic void model(input int r, input int ar, input int k,
                                output logic [7:0] cnt, output logic ex, output logic en);
    int t;
    t = (k < 0) ? 0 : k / P;
    if (ar != 0) begin
      cnt = 8'(r - (t % (r + 1))); ex = (t >= r + 1); en = 1'b1;
    end else if (t >= r + 1) begin
      cnt = 8'd0; ex = 1'b1; en = 1'b0;
    end else begin
      cnt = 8'(r - t); ex = 1'b0; en = 1'b1;
    end
  endfunction

  typedef struct {
    bit         w;
    logic [1:0] off;
    logic [7:0] wd;
    logic [7:0] exp;
  } vec_t;

  vec_t vt[14];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d, ecnt;
    logic       eex, een;
    int         a, e, seen, lat;
    bit         ok;

    vt[0]  = '{0, O_CTRL, 8'h00, 8'h00};
    vt[1]  = '{0, O_STAT, 8'h00, 8'h00};
    vt[2]  = '{0, O_REL,  8'h00, 8'hFF};
    vt[3]  = '{0, O_CNT,  8'h00, 8'h00};
    vt[4]  = '{1, O_REL,  8'hA5, 8'h00};
    vt[5]  = '{0, O_REL,  8'h00, 8'hA5};
    vt[6]  = '{1, O_CTRL, 8'hF6, 8'h00};
    vt[7]  = '{0, O_CTRL, 8'h00, 8'h06};
    vt[8]  = '{1, O_CNT,  8'h3C, 8'h00};
    vt[9]  = '{0, O_CNT,  8'h00, 8'h3C};
    vt[10] = '{1, O_STAT, 8'h02, 8'h00};
    vt[11] = '{0, O_STAT, 8'h00, 8'h00};
    vt[12] = '{1, O_CTRL, 8'h00, 8'h00};
    vt[13] = '{0, O_CTRL, 8'h00, 8'h00};

    rst = 1'b1; cyc0 = 0; cyc3 = 0; stb = 0; we = 0; int_ack = 0; adr = 0; dat_i = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ack", ack0, 0);
    chk("rst_dat", dat0, 8'h00);
    chk("rst_irq", irq0, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Register access vectors
    for (int i = 0; i < 14; i++) begin
      xfer(0, vt[i].w, vt[i].off, vt[i].wd, d, a);
      if (!vt[i].w) chk($sformatf("vec%0d_rdata", i), d, vt[i].exp);
    end

    // Auto-reload countdown: 03, 02, 01, 00 then reload with expiry
    xfer(0, 1, O_REL, 8'h03, d, a);
    xfer(0, 1, O_CTRL, 8'h07, d, a);
    e = a + 1;
    for (int i = 0; i < 4; i++) begin
      wait_edge(e + 4 * i);
      xfer(0, 0, O_CNT, 8'h00, d, a);
      chk($sformatf("countdown%0d", i), d, 8'(3 - i));
    end
    wait_edge(e + 16);
    xfer(0, 0, O_CNT, 8'h00, d, a);
    chk("reload_after_expiry", d, 8'h03);
    xfer(0, 0, O_STAT, 8'h00, d, a);
    chk("status_after_expiry", d, 8'h03);
    chk("irq_after_expiry", irq0, 1);

    // Interrupt acknowledge and W1C
    xfer(0, 1, O_CTRL, 8'h02, d, a);
    int_ack = 1'b1;
    @(posedge clk); #1;
    int_ack = 1'b0;
    @(negedge clk);
    chk("irq_after_int_ack", irq0, 0);
    @(posedge clk); #1;
    xfer(0, 0, O_STAT, 8'h00, d, a);
    chk("exp_kept_after_int_ack", d, 8'h01);
    xfer(0, 1, O_STAT, 8'h01, d, a);
    xfer(0, 0, O_STAT, 8'h00, d, a);
    chk("status_after_w1c", d, 8'h00);

    // One-shot
    xfer(0, 1, O_REL, 8'h01, d, a);
    xfer(0, 1, O_CTRL, 8'h03, d, a);
    e = a + 1;
    wait_edge(e + 20);
    xfer(0, 0, O_CTRL, 8'h00, d, a);
    chk("oneshot_en_cleared", d, 8'h02);
    xfer(0, 0, O_CNT, 8'h00, d, a);
    chk("oneshot_count", d, 8'h00);
    xfer(0, 0, O_STAT, 8'h00, d, a);
    chk("oneshot_status", d, 8'h03);
    xfer(0, 1, O_STAT, 8'h01, d, a);
    repeat (20) begin @(posedge clk); #1; end
    xfer(0, 0, O_STAT, 8'h00, d, a);
    chk("oneshot_single_expiry", d, 8'h00);
    xfer(0, 1, O_CTRL, 8'h00, d, a);

    // Abort during WAIT on the three-wait-state instance
    cyc3 = 1'b1; stb = 1'b1; we = 1'b1; adr = BASE + 8'd2; dat_i = 8'h55;
    seen = 0;
    repeat (2) begin
      @(negedge clk); if (ack3) seen = 1;
      @(posedge clk); #1;
    end
    cyc3 = 1'b0; stb = 1'b0; we = 1'b0;
    repeat (8) begin @(negedge clk); if (ack3) seen = 1; end
    @(posedge clk); #1;
    chk("abort_no_ack", seen, 0);
    xfer(1, 0, O_REL, 8'h00, d, a);
    chk("abort_no_write", d, 8'hFF);

    // Address miss
    bus(0, 0, BASE + 8'd4, 8'h00, 10, d, ok, lat, a);
    chk("miss_no_ack", ok, 0);

    // Expiry and STATUS W1C on the same edge
    xfer(0, 1, O_REL, 8'h00, d, a);
    xfer(0, 1, O_CTRL, 8'h07, d, a);
    e = a + 1;
    wait_edge(e + 5);
    xfer(0, 1, O_STAT, 8'h01, d, a);
    chk("w1c_commit_on_tick", a + 1, e + 8);
    @(negedge clk);
    chk("irq_set_wins", irq0, 1);
    @(posedge clk); #1;
    xfer(0, 0, O_STAT, 8'h00, d, a);
    chk("status_set_wins", d, 8'h03);
    xfer(0, 1, O_CTRL, 8'h00, d, a);
    xfer(0, 1, O_STAT, 8'h01, d, a);

    // Randomized trials against the arithmetic model
    for (int t = 0; t < 20; t++) begin
      int r, ar, dly;
      r   = int'($urandom_range(0, 7));
      ar  = int'($urandom_range(0, 1));
      dly = int'($urandom_range(0, 40));
      xfer(0, 1, O_CTRL, 8'h00, d, a);
      xfer(0, 1, O_STAT, 8'h01, d, a);
      xfer(0, 1, O_REL, 8'(r), d, a);
      xfer(0, 1, O_CTRL, (ar != 0) ? 8'h07 : 8'h03, d, a);
      e = a + 1;
      repeat (dly) begin @(posedge clk); #1; end
      xfer(0, 0, O_CNT, 8'h00, d, a);
      model(r, ar, a - 1 - e, ecnt, eex, een);
      chk($sformatf("rnd%0d_count", t), d, ecnt);
      xfer(0, 0, O_STAT, 8'h00, d, a);
      model(r, ar, a - 1 - e, ecnt, eex, een);
      chk($sformatf("rnd%0d_status", t), d, {6'b0, eex, eex});
      xfer(0, 0, O_CTRL, 8'h00, d, a);
      model(r, ar, a - 1 - e, ecnt, eex, een);
      chk($sformatf("rnd%0d_ctrl", t), d, {5'b0, ar[0], 1'b1, een});
    end

    // Reset in the middle of a WAIT
    xfer(1, 1, O_REL, 8'h5A, d, a);
    xfer(0, 1, O_REL, 8'h33, d, a);
    xfer(0, 1, O_CTRL, 8'h07, d, a);
    cyc3 = 1'b1; stb = 1'b1; we = 1'b1; adr = BASE + 8'd2; dat_i = 8'h77;
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      if (c == 2) rst = 1'b1;
      if (c == 3) begin rst = 1'b0; cyc3 = 1'b0; stb = 1'b0; we = 1'b0; end
      @(negedge clk); if (ack3) seen = 1;
      @(posedge clk); #1;
    end
    chk("rst_in_wait_no_ack", seen, 0);
    xfer(1, 0, O_CTRL, 8'h00, d, a); chk("rst3_ctrl", d, 8'h00);
    xfer(1, 0, O_STAT, 8'h00, d, a); chk("rst3_status", d, 8'h00);
    xfer(1, 0, O_REL,  8'h00, d, a); chk("rst3_reload", d, 8'hFF);
    xfer(1, 0, O_CNT,  8'h00, d, a); chk("rst3_count", d, 8'h00);
    xfer(0, 0, O_REL,  8'h00, d, a); chk("rst0_reload", d, 8'hFF);
    xfer(0, 0, O_CTRL, 8'h00, d, a); chk("rst0_ctrl", d, 8'h00);
    chk("rst0_irq", irq0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_gumnut_port_timer
`default_nettype wire
